// File: rtl/mem_cmd_burst_splitter_if.sv
// Command / burst / status bundle for the memory command burst splitter.
//
// Handshake rule for every channel in this bundle: a transfer happens on a
// rising clock edge where valid and ready are both 1. A source holds valid
// and its payload stable until that transfer. A sink may assert ready
// combinationally from valid.
//
// The splitter connects to the master modport. The command producer and the
// burst/status consumer connect to the slave modport.
interface mem_cmd_burst_splitter_if #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int LEN_WIDTH  = 32,
  parameter int CH_WIDTH   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0]            s_cmd_valid;
  logic [NUM_CH-1:0]            s_cmd_ready;
  logic [NUM_CH*ADDR_WIDTH-1:0] s_cmd_address;
  logic [NUM_CH*LEN_WIDTH-1:0]  s_cmd_length;

  logic                         m_burst_valid;
  logic                         m_burst_ready;
  logic [ADDR_WIDTH-1:0]        m_burst_addr;
  logic [7:0]                   m_burst_len;
  logic [CH_WIDTH-1:0]          m_burst_dest;
  logic                         m_burst_last;

  logic                         m_status_valid;
  logic                         m_status_ready;
  logic [7:0]                   m_status_data;

  modport master (
    input  s_cmd_valid, s_cmd_address, s_cmd_length, m_burst_ready, m_status_ready,
    output s_cmd_ready, m_burst_valid, m_burst_addr, m_burst_len, m_burst_dest,
           m_burst_last, m_status_valid, m_status_data
  );

  modport slave (
    output s_cmd_valid, s_cmd_address, s_cmd_length, m_burst_ready, m_status_ready,
    input  s_cmd_ready, m_burst_valid, m_burst_addr, m_burst_len, m_burst_dest,
           m_burst_last, m_status_valid, m_status_data
  );
endinterface

// File: rtl/mem_cmd_burst_splitter.sv
// Round-robin command arbiter plus burst splitter. One command is in flight
// at a time; it is cut into bursts limited by MAX_BURST_BEATS and by the
// BOUNDARY_BYTES boundary, then a single status byte closes the command.
module mem_cmd_burst_splitter #(
  parameter int NUM_CH          = 2,
  parameter int ADDR_WIDTH      = 64,
  parameter int LEN_WIDTH       = 32,
  parameter int DATA_BYTES      = 64,
  parameter int MAX_BURST_BEATS = 64,
  parameter int BOUNDARY_BYTES  = 4096,
  localparam int CH_WIDTH       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mem_cmd_burst_splitter_if.master bus,
  output logic [1:0]               dbg_state
);

  localparam int DB_LOG  = $clog2(DATA_BYTES);
  localparam int BND_LOG = $clog2(BOUNDARY_BYTES);
  localparam int LW1     = LEN_WIDTH + 1;
  localparam int CW0     = (LW1 > BND_LOG + 1) ? LW1 : BND_LOG + 1;
  // Common width wide enough for remaining beats, boundary room and 256.
  localparam int CW      = (CW0 > 9) ? CW0 : 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPLIT  = 2'd1,
    STATUS = 2'd2
  } state_t;

  state_t                state;
  logic [CH_WIDTH-1:0]   rr_ptr;
  logic [CH_WIDTH-1:0]   ch_q;
  logic [ADDR_WIDTH-1:0] addr_q;     // start of the burst after the one presented
  logic [LW1-1:0]        rem_q;      // beats left after the one presented

  logic [CH_WIDTH-1:0]   grant;
  logic                  grant_found;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [LW1-1:0]        cmd_beats;
  logic [8:0]            first_n;
  logic [8:0]            next_n;

  // Beats in the next burst: bounded by what is left, the burst cap and the
  // room up to the next boundary (address is already beat aligned).
  function automatic logic [8:0] calc_n(input logic [ADDR_WIDTH-1:0] a,
                                        input logic [LW1-1:0] rem);
    logic [CW-1:0] room;
    logic [CW-1:0] n;
    room = (CW'(BOUNDARY_BYTES) - CW'(a[BND_LOG-1:0])) >> DB_LOG;
    n    = CW'(rem);
    if (CW'(MAX_BURST_BEATS) < n) n = CW'(MAX_BURST_BEATS);
    if (room < n) n = room;
    return n[8:0];
  endfunction

  function automatic logic [7:0] status_byte(input logic err,
                                             input logic [CH_WIDTH-1:0] ch);
    logic [7:0] s;
    s = 8'd0;
    s[CH_WIDTH-1:0] = ch;
    s[7] = err;
    return s;
  endfunction

  assign dbg_state = state;

  // Round-robin pick: first valid channel at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_CH;
      if (!grant_found && bus.s_cmd_valid[idx]) begin
        grant_found = 1'b1;
        grant       = CH_WIDTH'(idx);
      end
    end
  end

  // Ready only to the granted channel, only while idle and out of reset.
  always_comb begin
    bus.s_cmd_ready = '0;
    if (rst_n && state == IDLE && grant_found) bus.s_cmd_ready[grant] = 1'b1;
  end

  // Decode the granted command and size the first and following bursts.
  always_comb begin
    cmd_addr  = bus.s_cmd_address[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH]
                & ~ADDR_WIDTH'(DATA_BYTES - 1);
    cmd_len   = bus.s_cmd_length[int'(grant)*LEN_WIDTH +: LEN_WIDTH];
    cmd_beats = ({1'b0, cmd_len} + LW1'(DATA_BYTES - 1)) >> DB_LOG;
    first_n   = calc_n(cmd_addr, cmd_beats);
    next_n    = calc_n(addr_q, rem_q);
  end

  // Control FSM; all burst and status outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      rr_ptr             <= '0;
      ch_q               <= '0;
      addr_q             <= '0;
      rem_q              <= '0;
      bus.m_burst_valid  <= 1'b0;
      bus.m_burst_addr   <= '0;
      bus.m_burst_len    <= '0;
      bus.m_burst_dest   <= '0;
      bus.m_burst_last   <= 1'b0;
      bus.m_status_valid <= 1'b0;
      bus.m_status_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            ch_q   <= grant;
            rr_ptr <= (grant == CH_WIDTH'(NUM_CH - 1)) ? '0 : grant + 1'b1;
            if (cmd_len == '0) begin
              state              <= STATUS;
              bus.m_status_valid <= 1'b1;
              bus.m_status_data  <= status_byte(1'b1, grant);
            end else begin
              state             <= SPLIT;
              bus.m_burst_valid <= 1'b1;
              bus.m_burst_addr  <= cmd_addr;
              bus.m_burst_len   <= 8'(first_n - 9'd1);
              bus.m_burst_dest  <= grant;
              bus.m_burst_last  <= (LW1'(first_n) == cmd_beats);
              addr_q            <= cmd_addr + (ADDR_WIDTH'(first_n) << DB_LOG);
              rem_q             <= cmd_beats - LW1'(first_n);
            end
          end
        end
        SPLIT: begin
          if (bus.m_burst_ready) begin
            if (bus.m_burst_last) begin
              state              <= STATUS;
              bus.m_burst_valid  <= 1'b0;
              bus.m_status_valid <= 1'b1;
              bus.m_status_data  <= status_byte(1'b0, ch_q);
            end else begin
              bus.m_burst_addr <= addr_q;
              bus.m_burst_len  <= 8'(next_n - 9'd1);
              bus.m_burst_last <= (LW1'(next_n) == rem_q);
              addr_q           <= addr_q + (ADDR_WIDTH'(next_n) << DB_LOG);
              rem_q            <= rem_q - LW1'(next_n);
            end
          end
        end
        STATUS: begin
          if (bus.m_status_ready) begin
            state              <= IDLE;
            bus.m_status_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_cmd_burst_splitter.sv
// Bench for mem_cmd_burst_splitter: directed scenarios with hand-computed
// expectations, then random commands checked against an arithmetic model.
module tb_mem_cmd_burst_splitter;

  localparam int NUM_CH = 2;
  localparam int AW     = 64;
  localparam int LW     = 32;
  localparam int CH_W   = 1;
  localparam int BW     = AW + 8 + CH_W + 1;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  mem_cmd_burst_splitter_if #(
    .NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .CH_WIDTH(CH_W)
  ) bus ();

  mem_cmd_burst_splitter #(
    .NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_BYTES(64),
    .MAX_BURST_BEATS(64), .BOUNDARY_BYTES(4096)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [BW-1:0]     exp_b[$];
  logic [7:0]        exp_s[$];
  int                acc_log[$];
  int                n_checks;
  int                n_err;
  bit                busy;
  bit                stall_b;
  bit                stall_s;
  bit                use_model;
  logic [NUM_CH-1:0] pend;
  int                rr_m;
  int                bursts_seen;
  int                bp_mode;
  logic [BW-1:0]     saved_b;
  logic [7:0]        saved_s;
  logic [AW-1:0]     cmd_addr[NUM_CH];
  logic [LW-1:0]     cmd_len[NUM_CH];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] cur_b();
    return {bus.m_burst_addr, bus.m_burst_len, bus.m_burst_dest, bus.m_burst_last};
  endfunction

  task automatic exp_burst(input logic [AW-1:0] a, input logic [7:0] l, input int d, input bit last);
    exp_b.push_back({a, l, CH_W'(d), last});
  endtask

  // Reference: walk the command beat-by-burst with plain arithmetic.
  task automatic model(input int ch, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    logic [AW-1:0] a;
    logic [63:0]   beats;
    logic [63:0]   n;
    logic [63:0]   room;
    if (len == 0) begin
      exp_s.push_back(8'h80 | 8'(ch));
      return;
    end
    a     = addr & ~64'd63;
    beats = (64'(len) + 64'd63) / 64'd64;
    while (beats != 0) begin
      n = beats;
      if (n > 64'd64) n = 64'd64;
      room = (64'd4096 - (a % 64'd4096)) / 64'd64;
      if (room < n) n = room;
      exp_b.push_back({a, 8'(n - 64'd1), CH_W'(ch), (n == beats)});
      a     = a + n * 64'd64;
      beats = beats - n;
    end
    exp_s.push_back(8'(ch));
  endtask

  // Driver: raise one channel's command
  task automatic set_cmd(input int ch, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    cmd_addr[ch] = addr;
    cmd_len[ch]  = len;
    bus.s_cmd_address[ch*AW +: AW] = addr;
    bus.s_cmd_length[ch*LW +: LW]  = len;
    bus.s_cmd_valid[ch] = 1'b1;
    pend[ch] = 1'b1;
  endtask

  // One clock: observe at negedge, then drive just after posedge.
  task automatic tick();
    int g;
    bit acc;
    bit st_hs;
    logic [NUM_CH-1:0] exp_r;
    g = -1; acc = 0; st_hs = 0;
    @(negedge clk);
    if (stall_b) begin
      check("burst_hold_valid", 128'(bus.m_burst_valid), 128'(1));
      if (bus.m_burst_valid) check("burst_stable", 128'(cur_b()), 128'(saved_b));
    end
    if (bus.m_burst_valid) begin
      if (bus.m_burst_ready) begin
        if (exp_b.size() == 0) check("burst_unexpected", 128'(cur_b()), 128'(0));
        else check("burst", 128'(cur_b()), 128'(exp_b.pop_front()));
        bursts_seen++;
        stall_b = 0;
      end else begin
        stall_b = 1;
        saved_b = cur_b();
      end
    end else stall_b = 0;
    if (stall_s) begin
      check("status_hold_valid", 128'(bus.m_status_valid), 128'(1));
      if (bus.m_status_valid) check("status_stable", 128'(bus.m_status_data), 128'(saved_s));
    end
    if (bus.m_status_valid) begin
      if (bus.m_status_ready) begin
        if (exp_s.size() == 0) check("status_unexpected", 128'(bus.m_status_data), 128'(0));
        else check("status", 128'(bus.m_status_data), 128'(exp_s.pop_front()));
        st_hs = 1;
        stall_s = 0;
      end else begin
        stall_s = 1;
        saved_s = bus.m_status_data;
      end
    end else stall_s = 0;
    if (busy) begin
      check("cmd_ready_busy", 128'(bus.s_cmd_ready), 128'(0));
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        int c;
        c = (rr_m + i) % NUM_CH;
        if (g < 0 && pend[c]) g = c;
      end
      exp_r = '0;
      if (g >= 0) exp_r[g] = 1'b1;
      check("cmd_ready", 128'(bus.s_cmd_ready), 128'(exp_r));
      if (g >= 0) begin
        acc  = 1;
        busy = 1;
        acc_log.push_back(g);
        rr_m = (g + 1) % NUM_CH;
        if (use_model) model(g, cmd_addr[g], cmd_len[g]);
      end
    end
    @(posedge clk);
    #1;
    if (st_hs) busy = 0;
    if (acc) begin
      bus.s_cmd_valid[g] = 1'b0;
      pend[g] = 1'b0;
    end
    case (bp_mode)
      0: begin
        bus.m_burst_ready  = 1'b1;
        bus.m_status_ready = 1'b1;
      end
      1: begin
        bus.m_burst_ready  = ($urandom_range(0, 3) != 0);
        bus.m_status_ready = ($urandom_range(0, 2) != 0);
      end
      default: ;
    endcase
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i;
    i = 0;
    while ((pend != 0 || busy) && i < budget) begin
      tick();
      i++;
    end
    check({tag, "_done"}, 128'(pend == 0 && !busy), 128'(1));
    check({tag, "_queues_empty"}, 128'(exp_b.size() + exp_s.size()), 128'(0));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_burst_valid"}, 128'(bus.m_burst_valid), 128'(0));
    check({tag, "_burst_fields"}, 128'(cur_b()), 128'(0));
    check({tag, "_status_valid"}, 128'(bus.m_status_valid), 128'(0));
    check({tag, "_status_data"}, 128'(bus.m_status_data), 128'(0));
    check({tag, "_cmd_ready"}, 128'(bus.s_cmd_ready), 128'(0));
    check({tag, "_state"}, 128'(dbg_state), 128'(0));
  endtask

  // Guard against a hung run
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1, "watchdog");
  end

  // Directed steps, then random traffic
  initial begin
    int start;
    logic [AW-1:0] ra;
    logic [LW-1:0] rl;
    n_checks = 0; n_err = 0; busy = 0; stall_b = 0; stall_s = 0;
    use_model = 0; pend = '0; rr_m = 0; bursts_seen = 0; bp_mode = 0;
    rst_n = 1'b0;
    bus.s_cmd_valid    = '0;
    bus.s_cmd_address  = '0;
    bus.s_cmd_length   = '0;
    bus.m_burst_ready  = 1'b1;
    bus.m_status_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      cmd_addr[i] = '0;
      cmd_len[i]  = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    tick();
    check_zero("after_reset");

    // Ch0 8 KiB at 0: two full bursts split at 4 KiB
    exp_burst(64'h0, 8'd63, 0, 1'b0);
    exp_burst(64'h1000, 8'd63, 0, 1'b1);
    exp_s.push_back(8'h00);
    set_cmd(0, 64'h0, 32'd8192);
    wait_idle("ch0_8k", 200);

    // Ch1 256 B at 0xFC0: one beat before the boundary, three after
    exp_burst(64'hFC0, 8'd0, 1, 1'b0);
    exp_burst(64'h1000, 8'd2, 1, 1'b1);
    exp_s.push_back(8'h01);
    set_cmd(1, 64'hFC0, 32'd256);
    wait_idle("ch1_cross", 200);

    // Ch0 100 B: rounds up to two beats
    exp_burst(64'h2000, 8'd1, 0, 1'b1);
    exp_s.push_back(8'h00);
    set_cmd(0, 64'h2000, 32'd100);
    wait_idle("ch0_len100", 200);

    // Ch1 zero length: error status, no burst
    exp_s.push_back(8'h81);
    set_cmd(1, 64'h3000, 32'd0);
    wait_idle("ch1_len0", 200);

    // Backpressure: burst stall 5 cycles, status held 3 cycles, ch1 waiting
    use_model = 1;
    bp_mode = 2;
    bus.m_burst_ready  = 1'b1;
    bus.m_status_ready = 1'b0;
    set_cmd(0, 64'h100, 32'd8192);
    start = bursts_seen;
    for (int i = 0; i < 50 && bursts_seen == start; i++) tick();
    check("stall_first_burst", 128'(bursts_seen - start), 128'(1));
    bus.m_burst_ready = 1'b0;
    set_cmd(1, 64'h5000, 32'd200);
    repeat (5) tick();
    bus.m_burst_ready = 1'b1;
    for (int i = 0; i < 50 && !bus.m_status_valid; i++) tick();
    check("stall_status_seen", 128'(bus.m_status_valid), 128'(1));
    repeat (3) tick();
    bus.m_status_ready = 1'b1;
    bp_mode = 0;
    wait_idle("stall", 400);

    // Both channels requesting every round: grants must alternate 0,1,0,1...
    acc_log.delete();
    for (int r = 0; r < 3; r++) begin
      set_cmd(0, {$urandom, $urandom}, 32'($urandom_range(1, 6000)));
      set_cmd(1, {$urandom, $urandom}, 32'($urandom_range(1, 6000)));
      wait_idle("arb", 2000);
    end
    for (int i = 0; i < 6; i++) check("arb_order", 128'(acc_log[i]), 128'(i % 2));

    // Address wrap at the top of the address space
    set_cmd(0, 64'hFFFF_FFFF_FFFF_FFC0, 32'd256);
    wait_idle("wrap", 200);

    // Random commands under random backpressure
    bp_mode = 1;
    for (int it = 0; it < 30; it++) begin
      int mask;
      mask = $urandom_range(1, 3);
      for (int c = 0; c < NUM_CH; c++) begin
        if (mask[c]) begin
          case ($urandom_range(0, 2))
            0: ra = {$urandom, $urandom};
            1: ra = 64'hFFFF_FFFF_FFFF_E000 | 64'($urandom_range(0, 8191));
            default: ra = 64'(32'h0001_0F00 + $urandom_range(0, 255));
          endcase
          case ($urandom_range(0, 4))
            0: rl = 32'd0;
            1: rl = 32'($urandom_range(1, 130));
            default: rl = 32'($urandom_range(1, 20000));
          endcase
          set_cmd(c, ra, rl);
        end
      end
      wait_idle("rand", 5000);
    end
    bp_mode = 0;
    bus.m_burst_ready  = 1'b1;
    bus.m_status_ready = 1'b1;
    tick();

    // Reset while the second burst is presented
    use_model = 0;
    exp_burst(64'h0, 8'd63, 0, 1'b0);
    exp_burst(64'h1000, 8'd63, 0, 1'b1);
    exp_s.push_back(8'h00);
    set_cmd(0, 64'h0, 32'd8192);
    start = bursts_seen;
    for (int i = 0; i < 50 && bursts_seen == start; i++) tick();
    check("rst_second_valid", 128'(bus.m_burst_valid), 128'(1));
    check("rst_second_addr", 128'(bus.m_burst_addr), 128'(64'h1000));
    rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    exp_b.delete();
    exp_s.delete();
    busy = 0; stall_b = 0; stall_s = 0; rr_m = 0; pend = '0;
    bus.s_cmd_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Fresh start: ch0 and ch1 both pending, pointer back at 0 picks ch0
    use_model = 1;
    acc_log.delete();
    set_cmd(0, 64'h0, 32'd4096);
    set_cmd(1, 64'h40, 32'd64);
    wait_idle("post_reset", 400);
    check("post_reset_first_grant", 128'(acc_log[0]), 128'(0));
    check("post_reset_second_grant", 128'(acc_log[1]), 128'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_cmd_burst_splitter.md
Name: mem_cmd_burst_splitter

Overview:
Multi-channel read/write command front-end for the memory path. It arbitrates NUM_CH independent address/length command streams round-robin. Each granted command is split into AXI-MM-legal bursts that never exceed MAX_BURST_BEATS and never cross a BOUNDARY_BYTES boundary. Each burst is tagged with its source channel, and one completion status per command is returned once all of its bursts are accepted. It sits between the SGD engines' command generators and the axi_mm master.

Parameters:
NUM_CH, 2, number of command channels (1..16)
ADDR_WIDTH, 64, byte address width
LEN_WIDTH, 32, byte length width
DATA_BYTES, 64, bytes per beat (512-bit line); power of 2
MAX_BURST_BEATS, 64, max beats per burst (1..256); power of 2
BOUNDARY_BYTES, 4096, burst must not cross this; power of 2, >= DATA_BYTES
CH_WIDTH, max(1,clog2(NUM_CH)), derived; dest/tag width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_cmd_valid  in  NUM_CH  per-channel command valid
s_cmd_ready  out  NUM_CH  per-channel command ready
s_cmd_address  in  NUM_CH*ADDR_WIDTH  start byte address; channel i occupies slice i
s_cmd_length  in  NUM_CH*LEN_WIDTH  length in bytes
m_burst_valid  out  1  burst valid
m_burst_ready  in  1  burst ready
m_burst_addr  out  ADDR_WIDTH  burst start address, beat aligned
m_burst_len  out  8  beats-1 (axlen encoding)
m_burst_dest  out  CH_WIDTH  source channel
m_burst_last  out  1  final burst of the command
m_status_valid  out  1  completion valid
m_status_ready  in  1  completion ready
m_status_data  out  8  bit7 = zero-length error; bits[CH_WIDTH-1:0] = channel; other bits 0

Behaviour:
- Reset (async assert, sync release): state IDLE, rr pointer 0, all valid/ready outputs 0, data outputs 0.
- FSM states: IDLE, SPLIT, STATUS.
- IDLE:
  - grant = first asserted s_cmd_valid at or after rr pointer, wrapping.
  - s_cmd_ready is one-hot on grant, combinational from s_cmd_valid. No grant means all ready bits are 0.
  - On handshake:
    - latch addr with the low log2(DATA_BYTES) bits cleared.
    - latch beats_rem = ceil(length/DATA_BYTES), computed in LEN_WIDTH+1 bits.
    - latch ch = grant.
    - rr pointer <= grant+1 mod NUM_CH.
  - Length 0: go to STATUS with the error bit set. Otherwise go to SPLIT.
- SPLIT: first burst valid the cycle after command acceptance.
  - n = min(beats_rem, MAX_BURST_BEATS, (BOUNDARY_BYTES - addr mod BOUNDARY_BYTES)/DATA_BYTES).
  - Present addr, len = n-1, dest = ch, last = (n == beats_rem).
  - Outputs are registered and stable while valid && !ready.
  - On handshake: addr += n*DATA_BYTES; beats_rem -= n.
  - If not last: next burst is valid on the next cycle, giving 1 burst/cycle under continuous ready.
  - If last: m_burst_valid drops and the FSM goes to STATUS.
- STATUS: m_status_valid = 1 with {err, ch}, held until m_status_ready, then IDLE. A new command can be accepted on the cycle after the status handshake.
- Exactly one command is in flight; all s_cmd_ready bits are 0 outside IDLE.
- Address addition wraps modulo 2^ADDR_WIDTH without flagging.
- Reset mid-burst or mid-status: the command is dropped, no status is issued, and the FSM restarts clean.

Test Plan:
- Ch0: addr 0x0, len 8192 -> 2 bursts (0x0, len 63, last 0) and (0x1000, len 63, last 1), dest 0; then status 0x00.
- Ch1: addr 0x0FC0, len 256 -> bursts (0xFC0, len 0) and (0x1000, len 2, last 1); status 0x01.
- Len 100 at 0x2000 -> one burst (0x2000, len 1); len 0 on ch1 -> no burst, status 0x81.
- Ch0 and ch1 valid together, repeatedly -> grants alternate 0,1,0,1 and each command's bursts complete before the next ready.
- m_burst_ready held low 5 cycles mid-command, and m_status_ready delayed 3 cycles -> addr/len/dest/last stable, no duplicate or lost bursts, no new s_cmd_ready until status accepted.
- rst_n pulsed low during the second burst -> all outputs 0 immediately; after release a fresh ch0 command at 0x0 restarts with the rr pointer at 0.
